// File: rtl/key_debounce.sv
// key_debounce: conditions active-low push-button inputs.
// Each key passes through a 2-flop synchroniser and then a 4-state debounce
// FSM with its own counter. The module reports a clean active-high pressed
// level and one-cycle press and release pulses. All outputs are registered.
module key_debounce #(
    parameter int unsigned KEY_W   = 4,
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_hold,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_FILT = 2'd1,
        DOWN   = 2'd2,
        R_FILT = 2'd3
    } state_e;

    // The sample that moves the FSM out of a stable state is the first of
    // the CNT_MAX+1 stable samples. The window therefore closes once the
    // counter has seen CNT_MAX further samples, which is when cnt reaches
    // CNT_MAX-1.
    localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

    logic [KEY_W-1:0] sync1_q;
    logic [KEY_W-1:0] sync2_q;

    // Two-flop synchroniser. Both stages reset to 1, which means released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
            state_e      state_q, state_d;
            logic [19:0] cnt_q, cnt_d;
            logic        press_q, press_d;
            logic        release_q, release_d;
            logic        hold_q, hold_d;
            logic        key_sync;

            assign key_sync = sync2_q[gi];

            // State, counter and output registers for this key.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    hold_q    <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                    hold_q    <= hold_d;
                end
            end

            // Next-state, counter and pulse logic for this key.
            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (!key_sync) begin
                            state_d = P_FILT;
                            cnt_d   = '0;
                        end
                    end
                    P_FILT: begin
                        if (key_sync) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q >= CNT_LAST) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    DOWN: begin
                        if (key_sync) begin
                            state_d = R_FILT;
                            cnt_d   = '0;
                        end
                    end
                    R_FILT: begin
                        if (!key_sync) begin
                            state_d = DOWN;
                            cnt_d   = '0;
                        end else if (cnt_q >= CNT_LAST) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
                hold_d = (state_d == DOWN) || (state_d == R_FILT);
            end

            assign key_press[gi]   = press_q;
            assign key_release[gi] = release_q;
            assign key_hold[gi]    = hold_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce, simulated with CNT_MAX=9 and KEY_W=4.
// Directed scenarios check against hand-derived constants. Random traffic is
// checked against a run-length reference model.
module tb_key_debounce;

    localparam int CM = 9;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_in;
    logic [3:0] key_hold;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int tests_run = 0;
    int tests_failed = 0;

    key_debounce #(
        .KEY_W  (4),
        .CNT_MAX(20'd9)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .key_hold   (key_hold),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model. A key's pins reach the decision logic two edges late.
    // A key flips its debounced state after CM+1 consecutive samples that
    // disagree with that state. Any agreeing sample restarts the run.
    logic [3:0] m_s1, m_s2, m_ks;
    logic [3:0] m_hold, m_press, m_rel;
    int         m_run[4];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_s1 = 4'hF; m_s2 = 4'hF;
            m_hold = 4'h0; m_press = 4'h0; m_rel = 4'h0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            m_ks = m_s2;
            m_s2 = m_s1;
            m_s1 = key_in;
            m_press = 4'h0;
            m_rel = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if ((~m_ks[k]) != m_hold[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == CM + 1) begin
                        m_hold[k] = ~m_hold[k];
                        m_run[k] = 0;
                        if (m_hold[k]) m_press[k] = 1'b1;
                        else m_rel[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in = 4'hF;
        repeat (3) cyc();
        tests_run++;
        if ({key_hold, key_press, key_release} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_held outputs=%h exp=000", {key_hold, key_press, key_release});
        end
        sys_rst_n = 1'b1;
        for (int m = 0; m < 5; m++) begin
            cyc();
            tests_run++;
            if ({key_hold, key_press, key_release} !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset_release cyc=%0d outputs=%h exp=000", m, {key_hold, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        key_in = 4'b1110;
        for (int m = 1; m <= 14; m++) begin
            cyc();
            tests_run++;
            if (key_press !== ((m == 12) ? 4'b0001 : 4'b0000) ||
                key_hold !== ((m >= 12) ? 4'b0001 : 4'b0000) || key_release !== 4'b0000) begin
                tests_failed++;
                $display("FAIL clean_press cyc=%0d press=%b hold=%b rel=%b exp_press=%b exp_hold=%b", m,
                         key_press, key_hold, key_release, (m == 12) ? 4'b0001 : 4'b0000,
                         (m >= 12) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        for (int m = 0; m < 30; m++) begin
            key_in[1] = !((m < 5) || (m >= 6 && m < 11));
            cyc();
            tests_run++;
            if (key_press[1] !== 1'b0 || key_hold[1] !== 1'b0 || key_release[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce cyc=%0d press1=%b hold1=%b rel1=%b exp=0", m, key_press[1],
                         key_hold[1], key_release[1]);
            end
        end
    endtask

    task automatic test_release_bounce();
        // key 0 is held down from the clean-press test
        int rel_cnt = 0;
        for (int m = 0; m < 6; m++) begin
            key_in[0] = (m < 4);
            cyc();
            tests_run++;
            if (key_release[0] !== 1'b0 || key_hold[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL release_bounce cyc=%0d rel0=%b hold0=%b exp rel0=0 hold0=1", m,
                         key_release[0], key_hold[0]);
            end
        end
        key_in[0] = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            cyc();
            if (key_release[0] === 1'b1) rel_cnt++;
            tests_run++;
            if (key_release[0] !== (m == 12) || key_hold[0] !== (m < 12) || key_press[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL release cyc=%0d rel0=%b hold0=%b exp_rel0=%b exp_hold0=%b", m,
                         key_release[0], key_hold[0], m == 12, m < 12);
            end
        end
        tests_run++;
        if (rel_cnt != 1) begin
            tests_failed++;
            $display("FAIL release_pulse_count got=%0d exp=1", rel_cnt);
        end
    endtask

    task automatic test_simultaneous();
        key_in = 4'hF;
        repeat (15) cyc();
        key_in = 4'h6;
        for (int m = 1; m <= 14; m++) begin
            cyc();
            tests_run++;
            if (key_press !== ((m == 12) ? 4'b1001 : 4'b0000) ||
                key_hold !== ((m >= 12) ? 4'b1001 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL simultaneous cyc=%0d press=%b hold=%b exp_press=%b exp_hold=%b", m,
                         key_press, key_hold, (m == 12) ? 4'b1001 : 4'b0000,
                         (m >= 12) ? 4'b1001 : 4'b0000);
            end
        end
        key_in = 4'hF;
        repeat (15) cyc();
    endtask

    task automatic test_reset_mid_filter();
        key_in = 4'b1110;
        repeat (14) cyc();
        key_in = 4'b1010;
        repeat (8) cyc();     // key 2 now in its press filter with cnt=5
        tests_run++;
        if (key_hold !== 4'b0001 || key_press !== 4'b0000) begin
            tests_failed++;
            $display("FAIL pre_reset hold=%b press=%b exp hold=0001 press=0000", key_hold, key_press);
        end
        sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({key_hold, key_press, key_release} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_immediate outputs=%h exp=000", {key_hold, key_press, key_release});
        end
        repeat (2) cyc();
        sys_rst_n = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            cyc();
            tests_run++;
            if (key_press !== ((m == 12) ? 4'b0101 : 4'b0000) ||
                key_hold !== ((m >= 12) ? 4'b0101 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL reset_restart cyc=%0d press=%b hold=%b exp_press=%b exp_hold=%b", m,
                         key_press, key_hold, (m == 12) ? 4'b0101 : 4'b0000,
                         (m >= 12) ? 4'b0101 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        int remain[4];
        for (int k = 0; k < 4; k++) remain[k] = $urandom_range(1, 14);
        for (int m = 0; m < 3000; m++) begin
            for (int k = 0; k < 4; k++) begin
                remain[k]--;
                if (remain[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    remain[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 16);
                end
            end
            cyc();
            tests_run++;
            if (key_hold !== m_hold || key_press !== m_press || key_release !== m_rel ||
                (key_press & key_release) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL random cyc=%0d hold=%b press=%b rel=%b exp hold=%b press=%b rel=%b", m,
                         key_hold, key_press, key_release, m_hold, m_press, m_rel);
            end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_in = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_filter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
